riscv_lsu_axi4lite_master: RTL and testbench

RISCV_LSU_AXI4LITE_MASTER -- requirements
Module: riscv_lsu_axi4lite_master

---
 rtl/riscv_lsu_axi4lite_master.sv | 223 ++++++++++++++++++++++
 tb/tb_riscv_lsu_axi4lite_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_axi4lite_master.sv
// Single-outstanding LSU-to-AXI4-Lite bridge: AXI request one cycle after acceptance, response one cycle after R/B.
// Stalls the core (req_ready=0) until the transaction completes; define MISALIGN_CHECK_EN to reject misaligned accesses.
module riscv_lsu_axi4lite_master #(
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  axi_clk,
   input  logic                  axi_rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [63:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [63:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] maxi_araddr,
   output logic                  maxi_arvalid,
   input  logic                  maxi_arready,
   output logic [2:0]            maxi_arprot,
   input  logic [63:0]           maxi_rdata,
   input  logic [1:0]            maxi_rresp,
   input  logic                  maxi_rvalid,
   output logic                  maxi_rready,
   output logic [ADDR_WIDTH-1:0] maxi_awaddr,
   output logic                  maxi_awvalid,
   input  logic                  maxi_awready,
   output logic [2:0]            maxi_awprot,
   output logic [63:0]           maxi_wdata,
   output logic [7:0]            maxi_wstrb,
   output logic                  maxi_wvalid,
   input  logic                  maxi_wready,
   input  logic                  maxi_bvalid,
   input  logic [1:0]            maxi_bresp,
   output logic                  maxi_bready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_RESP
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_ready_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [63:0]           r_wdata;
   logic [7:0]            r_wstrb;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [63:0]           r_rsp_rdata;

   logic                  w_accept;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_rd_fire;
   logic                  w_rsp_fire;
   logic                  w_rsp_err;
   logic [7:0]            w_strb_base;
   logic [7:0]            w_strb;
   logic                  w_unused;

   // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
   assign w_unused = ^{maxi_rresp[0], maxi_bresp[0]};

   always_comb begin
      w_strb_base = 8'h01;
      case (req_size)
         2'd0:    w_strb_base = 8'h01;
         2'd1:    w_strb_base = 8'h03;
         2'd2:    w_strb_base = 8'h0F;
         default: w_strb_base = 8'hFF;
      endcase
   end

   // An 8-bit shift drops lanes past the dword boundary.
   assign w_strb = w_strb_base << req_addr[2:0];

`ifdef MISALIGN_CHECK_EN
   logic [2:0] w_align_mask;
   logic       w_misalign;

   always_comb begin
      w_align_mask = 3'b000;
      case (req_size)
         2'd0:    w_align_mask = 3'b000;
         2'd1:    w_align_mask = 3'b001;
         2'd2:    w_align_mask = 3'b011;
         default: w_align_mask = 3'b111;
      endcase
   end

   assign w_misalign = |(req_addr[2:0] & w_align_mask);
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_aw_hs      = 1'b0;
      w_w_hs       = 1'b0;
      w_rd_fire    = 1'b0;
      w_rsp_fire   = 1'b0;
      w_rsp_err    = 1'b0;
      req_ready    = 1'b0;
      maxi_arvalid = 1'b0;
      maxi_rready  = 1'b0;
      maxi_awvalid = 1'b0;
      maxi_wvalid  = 1'b0;
      maxi_bready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = r_ready_en;
            if (req_valid && r_ready_en) begin
               w_accept = 1'b1;
`ifdef MISALIGN_CHECK_EN
               if (w_misalign) begin
                  w_rsp_fire = 1'b1;
                  w_rsp_err  = 1'b1;
               end else if (req_we) begin
                  w_state_nxt = S_WR_REQ;
               end else begin
                  w_state_nxt = S_RD_ADDR;
               end
`else
               if (req_we) begin
                  w_state_nxt = S_WR_REQ;
               end else begin
                  w_state_nxt = S_RD_ADDR;
               end
`endif
            end
         end
         S_RD_ADDR: begin
            maxi_arvalid = 1'b1;
            if (maxi_arready) begin
               w_state_nxt = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            maxi_rready = 1'b1;
            if (maxi_rvalid) begin
               w_rd_fire   = 1'b1;
               w_rsp_fire  = 1'b1;
               w_rsp_err   = maxi_rresp[1];
               w_state_nxt = S_IDLE;
            end
         end
         S_WR_REQ: begin
            maxi_awvalid = !r_aw_done;
            maxi_wvalid  = !r_w_done;
            w_aw_hs      = !r_aw_done && maxi_awready;
            w_w_hs       = !r_w_done && maxi_wready;
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_state_nxt = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            maxi_bready = 1'b1;
            if (maxi_bvalid) begin
               w_rsp_fire  = 1'b1;
               w_rsp_err   = maxi_bresp[1];
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         r_state     <= S_IDLE;
         r_ready_en  <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ready_en  <= 1'b1;
         r_rsp_valid <= w_rsp_fire;
         if (w_rsp_fire) begin
            r_rsp_err <= w_rsp_err;
         end
         if (w_rd_fire) begin
            r_rsp_rdata <= maxi_rdata;
         end
         if (w_accept) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_wstrb   <= w_strb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_hs) begin
               r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
               r_w_done <= 1'b1;
            end
         end
      end
   end

   assign maxi_araddr = r_addr;
   assign maxi_awaddr = r_addr;
   assign maxi_wdata  = r_wdata;
   assign maxi_wstrb  = r_wstrb;
   assign maxi_arprot = 3'b000;
   assign maxi_awprot = 3'b000;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_err     = r_rsp_err;
   assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_riscv_lsu_axi4lite_master.sv
// Directed self-checking bench for riscv_lsu_axi4lite_master; inputs change and outputs are sampled 1ns after each rising edge.
module tb_riscv_lsu_axi4lite_master;

   logic        axi_clk = 1'b0;
   logic        axi_rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic [63:0] maxi_araddr;
   logic        maxi_arvalid;
   logic        maxi_arready;
   logic [2:0]  maxi_arprot;
   logic [63:0] maxi_rdata;
   logic [1:0]  maxi_rresp;
   logic        maxi_rvalid;
   logic        maxi_rready;
   logic [63:0] maxi_awaddr;
   logic        maxi_awvalid;
   logic        maxi_awready;
   logic [2:0]  maxi_awprot;
   logic [63:0] maxi_wdata;
   logic [7:0]  maxi_wstrb;
   logic        maxi_wvalid;
   logic        maxi_wready;
   logic        maxi_bvalid;
   logic [1:0]  maxi_bresp;
   logic        maxi_bready;

   int n_total = 0;
   int n_bad   = 0;

   riscv_lsu_axi4lite_master #(.ADDR_WIDTH(64)) dut (
      .axi_clk      (axi_clk),
      .axi_rst      (axi_rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .maxi_araddr  (maxi_araddr),
      .maxi_arvalid (maxi_arvalid),
      .maxi_arready (maxi_arready),
      .maxi_arprot  (maxi_arprot),
      .maxi_rdata   (maxi_rdata),
      .maxi_rresp   (maxi_rresp),
      .maxi_rvalid  (maxi_rvalid),
      .maxi_rready  (maxi_rready),
      .maxi_awaddr  (maxi_awaddr),
      .maxi_awvalid (maxi_awvalid),
      .maxi_awready (maxi_awready),
      .maxi_awprot  (maxi_awprot),
      .maxi_wdata   (maxi_wdata),
      .maxi_wstrb   (maxi_wstrb),
      .maxi_wvalid  (maxi_wvalid),
      .maxi_wready  (maxi_wready),
      .maxi_bvalid  (maxi_bvalid),
      .maxi_bresp   (maxi_bresp),
      .maxi_bready  (maxi_bready)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = sz;
      req_addr  = a;
      req_wdata = d;
   endtask

   // Store with AW and W accepted together, then an OKAY response.
   task automatic do_store(input string tag, input logic [1:0] sz, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] exp_strb);
      issue(1'b1, sz, a, d);
      chk({tag, "_rdy"}, {63'd0, req_ready}, 64'd1);
      step();
      req_valid = 1'b0;
      chk({tag, "_strb"}, {56'd0, maxi_wstrb}, {56'd0, exp_strb});
      chk({tag, "_wdata"}, maxi_wdata, d);
      maxi_awready = 1'b1;
      maxi_wready  = 1'b1;
      step();
      maxi_awready = 1'b0;
      maxi_wready  = 1'b0;
      maxi_bvalid  = 1'b1;
      maxi_bresp   = 2'b00;
      step();
      maxi_bvalid = 1'b0;
      chk({tag, "_rsp"}, {62'd0, rsp_valid, rsp_err}, 64'd2);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_rsp;
      axi_rst      = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_addr     = '0;
      req_wdata    = '0;
      maxi_arready = 1'b0;
      maxi_rdata   = '0;
      maxi_rresp   = 2'b00;
      maxi_rvalid  = 1'b0;
      maxi_awready = 1'b0;
      maxi_wready  = 1'b0;
      maxi_bvalid  = 1'b0;
      maxi_bresp   = 2'b00;
      step();
      step();
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_valids", {58'd0, maxi_arvalid, maxi_awvalid, maxi_wvalid, maxi_rready, maxi_bready, rsp_valid}, 64'd0);
      chk("rst_regs", maxi_araddr | maxi_wdata | {56'd0, maxi_wstrb} | rsp_rdata, 64'd0);
      chk("prot", {58'd0, maxi_arprot, maxi_awprot}, 64'd0);
      axi_rst = 1'b0;
      step();
      chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

      // Load dword at 0x1000 with one AR wait cycle.
      issue(1'b0, 2'd3, 64'h1000, 64'd0);
      step();
      req_valid = 1'b0;
      chk("ld_arvalid", {63'd0, maxi_arvalid}, 64'd1);
      chk("ld_araddr", maxi_araddr, 64'h1000);
      chk("ld_busy", {63'd0, req_ready}, 64'd0);
      step();
      chk("ld_ar_hold", {63'd0, maxi_arvalid}, 64'd1);
      maxi_arready = 1'b1;
      step();
      maxi_arready = 1'b0;
      chk("ld_rd_state", {62'd0, maxi_arvalid, maxi_rready}, 64'd1);
      maxi_rvalid = 1'b1;
      maxi_rdata  = 64'hDEADBEEF_CAFEF00D;
      maxi_rresp  = 2'b00;
      step();
      maxi_rvalid = 1'b0;
      chk("ld_rsp", {61'd0, rsp_valid, rsp_err, req_ready}, 64'd5);
      chk("ld_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
      maxi_rdata = 64'h0;
      step();
      chk("ld_pulse", {63'd0, rsp_valid}, 64'd0);
      chk("ld_hold", rsp_rdata, 64'hDEADBEEF_CAFEF00D);

      // Half store at 0x2006, AW accepted before W, SLVERR response.
      issue(1'b1, 2'd1, 64'h2006, 64'hABCD_0000_0000_0000);
      step();
      req_valid = 1'b0;
      chk("st_aw_w", {62'd0, maxi_awvalid, maxi_wvalid}, 64'd3);
      chk("st_awaddr", maxi_awaddr, 64'h2006);
      chk("st_wstrb", {56'd0, maxi_wstrb}, 64'hC0);
      maxi_awready = 1'b1;
      step();
      maxi_awready = 1'b0;
      chk("st_aw_first", {61'd0, maxi_awvalid, maxi_wvalid, maxi_bready}, 64'd2);
      maxi_wready = 1'b1;
      step();
      maxi_wready = 1'b0;
      chk("st_w_done", {61'd0, maxi_awvalid, maxi_wvalid, maxi_bready}, 64'd1);
      maxi_bvalid = 1'b1;
      maxi_bresp  = 2'b10;
      step();
      maxi_bvalid = 1'b0;
      maxi_bresp  = 2'b00;
      chk("st_err", {62'd0, rsp_valid, rsp_err}, 64'd3);
      chk("st_rdata_kept", rsp_rdata, 64'hDEADBEEF_CAFEF00D);

      // Store with AW and W in the same cycle.
      issue(1'b1, 2'd3, 64'h3000, 64'h0123_4567_89AB_CDEF);
      step();
      req_valid    = 1'b0;
      maxi_awready = 1'b1;
      maxi_wready  = 1'b1;
      step();
      maxi_awready = 1'b0;
      maxi_wready  = 1'b0;
      chk("st2_wr_resp", {61'd0, maxi_awvalid, maxi_wvalid, maxi_bready}, 64'd1);
      maxi_bvalid = 1'b1;
      step();
      maxi_bvalid = 1'b0;
      chk("st2_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
      step();
      chk("st2_single", {63'd0, rsp_valid}, 64'd0);

      // Back-to-back loads: second accepted while first response pulses.
      maxi_arready = 1'b1;
      issue(1'b0, 2'd3, 64'h4000, 64'd0);
      step();
      req_valid = 1'b0;
      step();
      maxi_rvalid = 1'b1;
      maxi_rdata  = 64'h1111_2222_3333_4444;
      step();
      maxi_rvalid = 1'b0;
      issue(1'b0, 2'd2, 64'h4008, 64'd0);
      chk("b2b_overlap", {62'd0, rsp_valid, req_ready}, 64'd3);
      step();
      req_valid = 1'b0;
      chk("b2b_ar2", {62'd0, maxi_arvalid, rsp_valid}, 64'd2);
      chk("b2b_araddr2", maxi_araddr, 64'h4008);
      step();
      maxi_arready = 1'b0;
      maxi_rvalid  = 1'b1;
      maxi_rdata   = 64'h5555_6666_7777_8888;
      step();
      maxi_rvalid = 1'b0;
      chk("b2b_rdata2", rsp_rdata, 64'h5555_6666_7777_8888);
      step();

      // Reset while waiting for read data drops the load.
      maxi_arready = 1'b1;
      issue(1'b0, 2'd3, 64'h5000, 64'd0);
      step();
      req_valid = 1'b0;
      step();
      maxi_arready = 1'b0;
      chk("rr_in_rd", {63'd0, maxi_rready}, 64'd1);
      axi_rst = 1'b1;
      step();
      chk("rr_valids", {57'd0, maxi_arvalid, maxi_awvalid, maxi_wvalid, maxi_rready, maxi_bready, rsp_valid, req_ready}, 64'd0);
      chk("rr_addr", maxi_araddr, 64'd0);
      axi_rst = 1'b0;
      step();
      chk("rr_ready", {63'd0, req_ready}, 64'd1);
      n_rsp = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) n_rsp++;
         step();
      end
      chk("rr_no_rsp", 64'(n_rsp), 64'd0);

      // Strobe table.
      do_store("sb0", 2'd0, 64'h7003, 64'h0000_0000_AA00_0000, 8'h08);
      do_store("sw4", 2'd2, 64'h7004, 64'h1234_5678_0000_0000, 8'hF0);
      do_store("sd0", 2'd3, 64'h7000, 64'hFFFF_0000_FFFF_0000, 8'hFF);

`ifdef MISALIGN_CHECK_EN
      issue(1'b0, 2'd2, 64'h1002, 64'd0);
      step();
      req_valid = 1'b0;
      chk("mis_no_ar", {63'd0, maxi_arvalid}, 64'd0);
      chk("mis_rsp", {61'd0, rsp_valid, rsp_err, req_ready}, 64'd7);
      step();
      chk("mis_pulse", {62'd0, rsp_valid, maxi_arvalid}, 64'd0);
`else
      do_store("sw6_trunc", 2'd2, 64'h7006, 64'h0000_5678_0000_0000, 8'hC0);
      issue(1'b0, 2'd2, 64'h1002, 64'd0);
      step();
      req_valid = 1'b0;
      chk("mis_ar", {63'd0, maxi_arvalid}, 64'd1);
      chk("mis_araddr", maxi_araddr, 64'h1002);
      maxi_arready = 1'b1;
      step();
      maxi_arready = 1'b0;
      maxi_rvalid  = 1'b1;
      maxi_rresp   = 2'b11;
      maxi_rdata   = 64'h0BAD_0BAD_0BAD_0BAD;
      step();
      maxi_rvalid = 1'b0;
      maxi_rresp  = 2'b00;
      chk("mis_decerr", {62'd0, rsp_valid, rsp_err}, 64'd3);
      step();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
